// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline package: stage-register state encoding
// and default channel widths used by the pipeline stages.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pstate_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_NCH    = 2;
    localparam int DEF_CTRL_W = 2;
    localparam int DEF_RN_W   = 5;
    localparam int DEF_SKID   = 1;

    // Held-entry count for a given state.
    function automatic logic [1:0] occ_of(input pstate_t s);
        unique case (s)
            ST_ONE:  occ_of = 2'd1;
            ST_FULL: occ_of = 2'd2;
            default: occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry {ctrl, rn, data} with load enable
// and synchronous clear; async reset to zero.
module pipe_entry_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int RN_W   = DEF_RN_W,
    parameter int DW     = DEF_NCH * DEF_DATA_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              en,
    input  logic              clr,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [RN_W-1:0]   d_rn,
    input  logic [DW-1:0]     d_data,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [RN_W-1:0]   q_rn,
    output logic [DW-1:0]     q_data
);

    // Clear wins over load; otherwise hold.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            q_ctrl <= '0;
            q_rn   <= '0;
            q_data <= '0;
        end else if (clr) begin
            q_ctrl <= '0;
            q_rn   <= '0;
            q_data <= '0;
        end else if (en) begin
            q_ctrl <= d_ctrl;
            q_rn   <= d_rn;
            q_data <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register: single entry or
// two-entry skid buffer with a registered in_ready.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NCH    = DEF_NCH,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int RN_W   = DEF_RN_W,
    parameter int SKID   = DEF_SKID
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic [RN_W-1:0]       in_rn,
    input  logic [NCH*DATA_W-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [RN_W-1:0]       out_rn,
    output logic [NCH*DATA_W-1:0] out_data,
    output logic [1:0]            occ
);

    localparam int DW = NCH * DATA_W;

    pstate_t state, state_nxt;

    logic in_fire;
    logic out_fire;
    logic main_en;
    logic skid_en;
    logic from_skid;

    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
    logic [RN_W-1:0]   main_rn,   skid_rn,   main_d_rn;
    logic [DW-1:0]     main_data, skid_data, main_d_data;

    assign out_valid = (state != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign occ       = occ_of(state);

    // Next state and entry load enables; flush overrides all.
    always_comb begin
        state_nxt = state;
        main_en   = 1'b0;
        skid_en   = 1'b0;
        from_skid = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_en   = 1'b1;
                        state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_en = 1'b1;
                    end else if (in_fire && SKID != 0) begin
                        skid_en   = 1'b1;
                        state_nxt = ST_FULL;
                    end else if (out_fire) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_en   = 1'b1;
                        from_skid = 1'b1;
                        state_nxt = ST_ONE;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= ST_EMPTY;
        else         state <= state_nxt;
    end

    if (SKID != 0) begin : g_skid
        logic rdy_q;
        // Registered ready: low only while both entries held.
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) rdy_q <= 1'b1;
            else         rdy_q <= (state_nxt != ST_FULL);
        end
        assign in_ready = rdy_q;
    end else begin : g_single
        assign in_ready = out_ready | ~out_valid;
    end

    assign main_d_ctrl = from_skid ? skid_ctrl : in_ctrl;
    assign main_d_rn   = from_skid ? skid_rn   : in_rn;
    assign main_d_data = from_skid ? skid_data : in_data;

    pipe_entry_reg #(
        .CTRL_W (CTRL_W),
        .RN_W   (RN_W),
        .DW     (DW)
    ) u_main (
        .clock  (clock),
        .resetn (resetn),
        .en     (main_en),
        .clr    (1'b0),
        .d_ctrl (main_d_ctrl),
        .d_rn   (main_d_rn),
        .d_data (main_d_data),
        .q_ctrl (main_ctrl),
        .q_rn   (main_rn),
        .q_data (main_data)
    );

    pipe_entry_reg #(
        .CTRL_W (CTRL_W),
        .RN_W   (RN_W),
        .DW     (DW)
    ) u_skid (
        .clock  (clock),
        .resetn (resetn),
        .en     (skid_en),
        .clr    (flush),
        .d_ctrl (in_ctrl),
        .d_rn   (in_rn),
        .d_data (in_data),
        .q_ctrl (skid_ctrl),
        .q_rn   (skid_rn),
        .q_data (skid_data)
    );

    // Bubbles carry no control so downstream writes stay off.
    assign out_ctrl = out_valid ? main_ctrl : '0;
    assign out_rn   = main_rn;
    assign out_data = main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: skid (2x32) and single-entry (1x16)
// stage registers against a queue-based reference model.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [1:0]  ctrl;
        logic [4:0]  rn;
        logic [63:0] data;
    } ent_t;

    logic clock = 1'b0;
    logic resetn = 1'b1;
    logic flush;
    logic out_ready;

    logic        in_valid1, in_ready1, out_valid1;
    logic [1:0]  in_ctrl1, out_ctrl1, occ1;
    logic [4:0]  in_rn1, out_rn1;
    logic [63:0] in_data1, out_data1;

    logic        in_valid0, in_ready0, out_valid0;
    logic [1:0]  in_ctrl0, out_ctrl0, occ0;
    logic [4:0]  in_rn0, out_rn0;
    logic [15:0] in_data0, out_data0;

    ent_t sb1[$];
    ent_t sb0[$];
    ent_t last1, last0, h;
    bit   exp_rdy1 = 1'b1;
    bit   exp_rdy0 = 1'b1;
    bit   acc1, acc0, fl;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    pipe_stage_reg u_dut1 (
        .clock     (clock),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_ctrl   (in_ctrl1),
        .in_rn     (in_rn1),
        .in_data   (in_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl1),
        .out_rn    (out_rn1),
        .out_data  (out_data1),
        .occ       (occ1)
    );

    pipe_stage_reg #(
        .DATA_W (16),
        .NCH    (1),
        .SKID   (0)
    ) u_dut0 (
        .clock     (clock),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .in_ctrl   (in_ctrl0),
        .in_rn     (in_rn0),
        .in_data   (in_data0),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl0),
        .out_rn    (out_rn0),
        .out_data  (out_data0),
        .occ       (occ0)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT outputs with the model head, pop on transfer out.
    always @(negedge clock) begin
        if (resetn) begin
            exp_rdy1 = (sb1.size() < 2);
            chk("in_ready1", 64'(in_ready1), 64'(exp_rdy1));
            chk("out_valid1", 64'(out_valid1), 64'(sb1.size() != 0));
            chk("occ1", 64'(occ1), 64'(sb1.size()));
            if (sb1.size() != 0) begin
                h = sb1[0];
                last1 = h;
                chk("ctrl1", 64'(out_ctrl1), 64'(h.ctrl));
                chk("rn1", 64'(out_rn1), 64'(h.rn));
                chk("data1", out_data1, h.data);
                if (out_ready && !flush) void'(sb1.pop_front());
            end else begin
                chk("bubble_ctrl1", 64'(out_ctrl1), 64'd0);
                chk("hold_rn1", 64'(out_rn1), 64'(last1.rn));
                chk("hold_data1", out_data1, last1.data);
            end

            exp_rdy0 = out_ready || (sb0.size() == 0);
            chk("in_ready0", 64'(in_ready0), 64'(exp_rdy0));
            chk("out_valid0", 64'(out_valid0), 64'(sb0.size() != 0));
            chk("occ0", 64'(occ0), 64'(sb0.size()));
            if (sb0.size() != 0) begin
                h = sb0[0];
                last0 = h;
                chk("ctrl0", 64'(out_ctrl0), 64'(h.ctrl));
                chk("rn0", 64'(out_rn0), 64'(h.rn));
                chk("data0", 64'(out_data0), h.data);
                if (out_ready && !flush) void'(sb0.pop_front());
            end else begin
                chk("bubble_ctrl0", 64'(out_ctrl0), 64'd0);
                chk("hold_rn0", 64'(out_rn0), 64'(last0.rn));
                chk("hold_data0", 64'(out_data0), last0.data);
            end
        end
    end

    // Advance one edge; push accepted entries, apply flush/reset to model.
    task automatic step();
        @(posedge clock);
        acc1 = 1'b0;
        acc0 = 1'b0;
        fl   = flush;
        if (!resetn) begin
            sb1.delete();
            sb0.delete();
            last1 = '0;
            last0 = '0;
        end else if (flush) begin
            sb1.delete();
            sb0.delete();
        end else begin
            if (in_valid1 && exp_rdy1) begin
                sb1.push_back('{in_ctrl1, in_rn1, in_data1});
                acc1 = 1'b1;
            end
            if (in_valid0 && exp_rdy0) begin
                sb0.push_back('{in_ctrl0, in_rn0, 64'(in_data0)});
                acc0 = 1'b1;
            end
        end
        #1;
    endtask

    task automatic offer1(input logic [1:0] c, input logic [4:0] r,
                          input logic [63:0] d);
        int n;
        n = 0;
        in_valid1 = 1'b1;
        in_ctrl1  = c;
        in_rn1    = r;
        in_data1  = d;
        do begin
            step();
            n++;
        end while (!acc1 && n < 40);
        chk("offer1_accept", 64'(acc1), 64'd1);
        in_valid1 = 1'b0;
    endtask

    initial begin
        logic [63:0] d;
        int n;
        flush = 0; out_ready = 0;
        in_valid1 = 0; in_ctrl1 = 0; in_rn1 = 0; in_data1 = 0;
        in_valid0 = 0; in_ctrl0 = 0; in_rn0 = 0; in_data0 = 0;
        last1 = '0; last0 = '0;
        #1 resetn = 1'b0;
        #10;
        chk("rst_occ1", 64'(occ1), 64'd0);
        chk("rst_valid1", 64'(out_valid1), 64'd0);
        chk("rst_ctrl1", 64'(out_ctrl1), 64'd0);
        chk("rst_data1", out_data1, 64'd0);
        chk("rst_rdy1", 64'(in_ready1), 64'd1);
        chk("rst_valid0", 64'(out_valid0), 64'd0);
        step();
        step();
        resetn = 1'b1;

        // Streaming at full rate.
        out_ready = 1'b1;
        for (int r = 1; r <= 8; r++)
            offer1(2'($urandom), 5'(r), {$urandom, $urandom});
        repeat (3) step();

        // Backpressure into the skid entry.
        out_ready = 1'b0;
        offer1(2'b01, 5'd3, 64'h3333);
        offer1(2'b10, 5'd4, 64'h4444);
        in_valid1 = 1'b1; in_rn1 = 5'd5; in_data1 = 64'h5555; in_ctrl1 = 2'b11;
        step();
        step();
        chk("bp_occ", 64'(occ1), 64'd2);
        chk("bp_rdy", 64'(in_ready1), 64'd0);
        chk("bp_head", 64'(out_rn1), 64'd3);
        out_ready = 1'b1;
        n = 0;
        do begin step(); n++; end while (!acc1 && n < 20);
        chk("bp_accept5", 64'(acc1), 64'd1);
        in_valid1 = 1'b0;
        repeat (4) step();

        // Flush while full with an offered entry.
        out_ready = 1'b0;
        offer1(2'b01, 5'd1, 64'h11);
        offer1(2'b01, 5'd2, 64'h22);
        in_valid1 = 1'b1; in_rn1 = 5'd7; in_ctrl1 = 2'b11; in_data1 = 64'h77;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid1 = 1'b0;
        chk("fl_occ", 64'(occ1), 64'd0);
        chk("fl_valid", 64'(out_valid1), 64'd0);
        chk("fl_ctrl", 64'(out_ctrl1), 64'd0);
        out_ready = 1'b1;
        repeat (3) step();

        // Bubble after a ctrl=11 entry drains.
        d = 64'hDEAD_BEEF_0123_4567;
        offer1(2'b11, 5'd9, d);
        repeat (2) step();
        chk("bub_valid", 64'(out_valid1), 64'd0);
        chk("bub_ctrl", 64'(out_ctrl1), 64'd0);
        chk("bub_data", out_data1, d);
        chk("bub_rn", 64'(out_rn1), 64'd9);

        // Single-entry mode: combinational ready and replace.
        out_ready = 1'b0;
        in_valid0 = 1'b1; in_ctrl0 = 2'b01; in_rn0 = 5'd10; in_data0 = 16'h1234;
        step();
        chk("s0_acc", 64'(acc0), 64'd1);
        in_valid0 = 1'b0;
        step();
        chk("s0_rdy_lo", 64'(in_ready0), 64'd0);
        out_ready = 1'b1;
        in_valid0 = 1'b1; in_ctrl0 = 2'b10; in_rn0 = 5'd11; in_data0 = 16'hABCD;
        #1;
        chk("s0_rdy_hi", 64'(in_ready0), 64'd1);
        step();
        chk("s0_acc2", 64'(acc0), 64'd1);
        in_valid0 = 1'b0;
        chk("s0_rn", 64'(out_rn0), 64'd11);
        chk("s0_occ", 64'(occ0), 64'd1);
        repeat (2) step();

        // Asynchronous reset while full.
        out_ready = 1'b0;
        offer1(2'b11, 5'd20, 64'h20);
        offer1(2'b11, 5'd21, 64'h21);
        #3 resetn = 1'b0;
        #1;
        chk("ar_occ", 64'(occ1), 64'd0);
        chk("ar_valid", 64'(out_valid1), 64'd0);
        chk("ar_ctrl", 64'(out_ctrl1), 64'd0);
        chk("ar_rdy", 64'(in_ready1), 64'd1);
        chk("ar_data", out_data1, 64'd0);
        step();
        step();
        resetn = 1'b1;

        // Random traffic; unaccepted offers are held unchanged.
        for (int c = 0; c < 1500; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            if (!(in_valid1 && !acc1 && !fl)) begin
                in_valid1 = ($urandom_range(0, 2) != 0);
                in_ctrl1  = 2'($urandom);
                in_rn1    = 5'($urandom);
                in_data1  = {$urandom, $urandom};
            end
            if (!(in_valid0 && !acc0 && !fl)) begin
                in_valid0 = ($urandom_range(0, 2) != 0);
                in_ctrl0  = 2'($urandom);
                in_rn0    = 5'($urandom);
                in_data0  = 16'($urandom);
            end
            step();
        end

        flush = 1'b0;
        out_ready = 1'b1;
        in_valid1 = 1'b0;
        in_valid0 = 1'b0;
        repeat (4) step();
        chk("drain1", 64'(sb1.size()), 64'd0);
        chk("drain0", 64'(sb0.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
